wb_port_arbiter: RTL and testbench

Arbitrates the single register-file write port between two write-back requesters: requester 0 (ALU/execute) and requester 1 (load unit). Each requester uses a valid/ready handshake. Accepted writes are captured in a registered output stage that drives the register file one cycle later. Fairness comes from a round-robin pointer, and a saturating counter reports write-port conflicts for performance monitoring.

---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wb_port_arbiter_if.sv | 39 +++
 rtl/wb_port_arbiter_rr_arb2.sv | 40 ++++
 rtl/wb_port_arbiter.sv | 74 +++++++
 tb/tb_wb_port_arbiter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the write-back port arbiter.
// Request payload widths here set the default (and required) data-path widths.
package wb_arb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 5;

    typedef logic req_idx_t;

    localparam req_idx_t REQ0 = 1'b0;
    localparam req_idx_t REQ1 = 1'b1;

    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Two valid/ready write-back requesters, a hold input, the registered write port and the conflict counter.
// Master modport is the requester/register-file side; slave modport is the arbiter.
interface wb_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  hold;
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_rd;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_rd;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  wb_en;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [CNT_WIDTH-1:0]  conflict_cnt;

    modport master (
        output hold,
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        input  wb_en, wb_rd, wb_data, conflict_cnt
    );

    modport slave (
        input  hold,
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        output wb_en, wb_rd, wb_data, conflict_cnt
    );
endinterface

// File: rtl/wb_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last_grant pointer advances on transfer.
// Zero latency; hold suppresses every grant and freezes the pointer.
module rr_arb2
    import wb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       hold,
    input  logic       transfer,
    output logic [1:0] grant
);

    req_idx_t last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= REQ1;
        end else if (transfer) begin
            last_grant <= grant[REQ1] ? REQ1 : REQ0;
        end
    end

    // On a conflict the requester that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        if (!hold) begin
            case (valid)
                2'b01:   grant[REQ0] = 1'b1;
                2'b10:   grant[REQ1] = 1'b1;
                2'b11: begin
                    if (last_grant == REQ1) grant[REQ0] = 1'b1;
                    else                    grant[REQ1] = 1'b1;
                end
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: round-robin between execute and load, one-cycle registered output.
// Readies are combinational; hold or rst blocks both requesters, which stay pending.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    if (DATA_WIDTH != WB_DATA_WIDTH || ADDR_WIDTH != WB_ADDR_WIDTH) begin : g_width_check
        $error("wb_port_arbiter: DATA_WIDTH/ADDR_WIDTH must match wb_req_t field widths");
    end

    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] RD_ZERO = ADDR_WIDTH'(ZERO_REG);

    logic [1:0] valid;
    logic [1:0] grant;
    logic       transfer;
    logic       conflict;
    wb_req_t    req0;
    wb_req_t    req1;
    wb_req_t    sel;

    assign valid = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .hold     (bus.hold),
        .transfer (transfer),
        .grant    (grant)
    );

    assign bus.req0_ready = grant[REQ0] & ~rst;
    assign bus.req1_ready = grant[REQ1] & ~rst;

    assign transfer = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);
    assign conflict = bus.req0_valid & bus.req1_valid & ~bus.hold;

    assign req0 = '{rd: bus.req0_rd, data: bus.req0_data};
    assign req1 = '{rd: bus.req1_rd, data: bus.req1_data};
    assign sel  = grant[REQ1] ? req1 : req0;

    // Writes to x0 are accepted and captured, but never enable the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wb_en   <= 1'b0;
            bus.wb_rd   <= '0;
            bus.wb_data <= '0;
        end else begin
            bus.wb_en <= transfer && (sel.rd != RD_ZERO);
            if (transfer) begin
                bus.wb_rd   <= sel.rd;
                bus.wb_data <= sel.data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.conflict_cnt <= '0;
        end else if (conflict && bus.conflict_cnt != CNT_MAX) begin
            bus.conflict_cnt <= bus.conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: main instance plus a 2-bit counter instance for saturation.
module tb_wb_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) bus ();
    wb_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(2))  sat ();

    wb_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sat)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                         input logic h);
        bus.req0_valid = v0;
        bus.req0_rd    = rd0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_rd    = rd1;
        bus.req1_data  = d1;
        bus.hold       = h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 5'd9, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        sat.hold = 1'b0;
        sat.req0_valid = 1'b0; sat.req0_rd = 5'd1; sat.req0_data = 32'h0;
        sat.req1_valid = 1'b0; sat.req1_rd = 5'd2; sat.req1_data = 32'h0;

        // Reset state, with a request pending that must not be accepted.
        step();
        chk("rst_wb_en",   bus.wb_en, 0);
        chk("rst_wb_rd",   bus.wb_rd, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_cnt",     bus.conflict_cnt, 0);
        chk("rst_rdy0",    bus.req0_ready, 0);
        step();
        chk("rst_wb_en2",  bus.wb_en, 0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        rst = 1'b0;
        step();

        // Single request from requester 0.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("t1_rdy0", bus.req0_ready, 1);
        chk("t1_rdy1", bus.req1_ready, 0);
        step();
        chk("t1_wb_en",   bus.wb_en, 1);
        chk("t1_wb_rd",   bus.wb_rd, 5);
        chk("t1_wb_data", bus.wb_data, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        chk("t1_wb_en_off", bus.wb_en, 0);
        chk("t1_wb_rd_keep", bus.wb_rd, 5);

        // x0 write from requester 1: accepted, no enable, pointer moves to 1.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0);
        #1;
        chk("x0_rdy1", bus.req1_ready, 1);
        step();
        chk("x0_wb_en",   bus.wb_en, 0);
        chk("x0_wb_data", bus.wb_data, 32'h1234);
        chk("x0_cnt",     bus.conflict_cnt, 0);

        // Continuous conflict: alternate starting with requester 0.
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_rdy0", bus.req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_rdy1", bus.req1_ready, (i % 2 == 0) ? 0 : 1);
            step();
            chk("rr_wb_en", bus.wb_en, 1);
            chk("rr_wb_rd", bus.wb_rd, (i % 2 == 0) ? 1 : 2);
            chk("rr_wb_data", bus.wb_data, (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        chk("rr_cnt", bus.conflict_cnt, 4);

        // Hold with both requests pending: nothing moves.
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_rdy0", bus.req0_ready, 0);
            chk("hold_rdy1", bus.req1_ready, 0);
            step();
            chk("hold_wb_en", bus.wb_en, 0);
            chk("hold_cnt", bus.conflict_cnt, 4);
        end
        bus.hold = 1'b0;
        #1;
        chk("unhold_rdy0", bus.req0_ready, 1);
        chk("unhold_rdy1", bus.req1_ready, 0);
        step();
        chk("unhold_wb_rd", bus.wb_rd, 1);
        chk("unhold_wb_en", bus.wb_en, 1);
        chk("unhold_cnt", bus.conflict_cnt, 5);

        // Requester 0 wins, then reset lands while its output is on the port.
        drive(1'b1, 5'd7, 32'hAA, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        chk("pre_rst_wb_en", bus.wb_en, 1);
        chk("pre_rst_wb_rd", bus.wb_rd, 7);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_wb_en",   bus.wb_en, 0);
        chk("mid_rst_wb_rd",   bus.wb_rd, 0);
        chk("mid_rst_wb_data", bus.wb_data, 0);
        chk("mid_rst_cnt",     bus.conflict_cnt, 0);
        chk("mid_rst_rdy0",    bus.req0_ready, 0);
        chk("mid_rst_rdy1",    bus.req1_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_rdy0", bus.req0_ready, 1);
        chk("post_rst_rdy1", bus.req1_ready, 0);
        step();
        chk("post_rst_wb_rd", bus.wb_rd, 3);
        chk("post_rst_cnt",   bus.conflict_cnt, 1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        // 2-bit counter saturates at 3.
        chk("sat_start", sat.conflict_cnt, 0);
        sat.req0_valid = 1'b1;
        sat.req1_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("sat_cnt", sat.conflict_cnt, (k > 3) ? 3 : k);
        end
        sat.req0_valid = 1'b0;
        sat.req1_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
